// File: rtl/fechadura_senha.sv
// rtl/fechadura_senha.sv - code-lock controller fed by a 4-bit digit register
//
// Collects N_DIGITOS digits delivered on Dado/Pronto, re-arming the upstream
// register through HabReg after each capture, and compares the entry against
// SENHA. A correct code opens the lock (Aberto) for T_ABERTO cycles; a wrong
// code pulses Erro; MAX_ERROS consecutive failures hold Bloqueado for
// T_BLOQUEIO cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   Dado       in   digit from the register output
//   Pronto     in   digit valid, from the register done flag
//   Limpar     in   discard the partial entry
//   HabReg     out  enable to the register; 0 re-arms it
//   Aberto     out  correct code, lock open
//   Erro       out  one-cycle pulse on a wrong code
//   Bloqueado  out  lockout active
//   Digitos    out  digits captured so far
module fechadura_senha #(
    parameter int                     N_DIGITOS  = 4,
    parameter logic [4*N_DIGITOS-1:0] SENHA      = 16'h1234,
    parameter int                     MAX_ERROS  = 3,
    parameter int                     T_ABERTO   = 8,
    parameter int                     T_BLOQUEIO = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       Dado,
    input  logic                             Pronto,
    input  logic                             Limpar,
    output logic                             HabReg,
    output logic                             Aberto,
    output logic                             Erro,
    output logic                             Bloqueado,
    output logic [$clog2(N_DIGITOS+1)-1:0]   Digitos
);

    localparam int BW    = 4 * N_DIGITOS;
    localparam int CW    = $clog2(N_DIGITOS + 1);
    localparam int EW    = $clog2(MAX_ERROS + 1);
    localparam int T_MAX = (T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_LIBERA,
        S_COLETA,
        S_VERIFICA,
        S_ABERTO,
        S_ERRO,
        S_BLOQUEIO
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic [BW-1:0]   buffer, buffer_n;
    logic [EW-1:0]   err, err_n;
    logic [TW-1:0]   timer, timer_n;

    always_comb begin
        state_n  = state;
        count_n  = count;
        buffer_n = buffer;
        err_n    = err;
        timer_n  = timer;

        case (state)
            S_LIBERA: begin
                if (Limpar) begin
                    count_n  = '0;
                    buffer_n = '0;
                    state_n  = S_LIBERA;
                end else if (count == CW'(N_DIGITOS)) begin
                    state_n = S_VERIFICA;
                end else begin
                    state_n = S_COLETA;
                end
            end
            S_COLETA: begin
                // Limpar has priority over a digit arriving in the same cycle
                if (Limpar) begin
                    count_n  = '0;
                    buffer_n = '0;
                    state_n  = S_LIBERA;
                end else if (Pronto) begin
                    buffer_n = BW'({buffer, Dado});
                    count_n  = count + 1'b1;
                    state_n  = S_LIBERA;
                end
            end
            S_VERIFICA: begin
                count_n  = '0;
                buffer_n = '0;
                if (buffer == SENHA) begin
                    err_n   = '0;
                    timer_n = TW'(T_ABERTO - 1);
                    state_n = S_ABERTO;
                end else if (({1'b0, err} + 1'b1) == (EW+1)'(MAX_ERROS)) begin
                    // counter parks at MAX_ERROS for the whole lockout
                    err_n   = EW'(MAX_ERROS);
                    timer_n = TW'(T_BLOQUEIO - 1);
                    state_n = S_BLOQUEIO;
                end else begin
                    err_n   = err + 1'b1;
                    state_n = S_ERRO;
                end
            end
            S_ABERTO: begin
                if (timer == '0) begin
                    state_n = S_LIBERA;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_ERRO: begin
                state_n = S_LIBERA;
            end
            S_BLOQUEIO: begin
                if (timer == '0) begin
                    err_n   = '0;
                    state_n = S_LIBERA;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = S_LIBERA;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_LIBERA;
            count     <= '0;
            buffer    <= '0;
            err       <= '0;
            timer     <= '0;
            HabReg    <= 1'b0;
            Aberto    <= 1'b0;
            Erro      <= 1'b0;
            Bloqueado <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            buffer    <= buffer_n;
            err       <= err_n;
            timer     <= timer_n;
            HabReg    <= (state_n == S_COLETA);
            Aberto    <= (state_n == S_ABERTO);
            Erro      <= (state_n == S_ERRO);
            Bloqueado <= (state_n == S_BLOQUEIO);
        end
    end

    assign Digitos = count;

endmodule

// File: tb/tb_fechadura_senha.sv
// tb/tb_fechadura_senha.sv - scoreboard bench for fechadura_senha
module tb_fechadura_senha;

    logic       clk;
    logic       rst;
    logic [3:0] Dado;
    logic       Pronto;
    logic       Limpar;
    logic       HabReg;
    logic       Aberto;
    logic       Erro;
    logic       Bloqueado;
    logic [2:0] Digitos;

    fechadura_senha dut (
        .clk       (clk),
        .rst       (rst),
        .Dado      (Dado),
        .Pronto    (Pronto),
        .Limpar    (Limpar),
        .HabReg    (HabReg),
        .Aberto    (Aberto),
        .Erro      (Erro),
        .Bloqueado (Bloqueado),
        .Digitos   (Digitos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = Aberto run, 1 = Erro run, 2 = Bloqueado run; len in cycles
    typedef struct {
        int kind;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   run_a, run_e, run_b;

    function automatic string kname(input int k);
        case (k)
            0:       return "aberto";
            1:       return "erro";
            default: return "bloqueado";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input int len);
        exp_t e;
        e.kind = kind;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic report(input int kind, input int len);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s len %0d expected none", kname(kind), len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.len != len) begin
                errors++;
                $display("FAIL event: got %s len %0d expected %s len %0d",
                         kname(kind), len, kname(e.kind), e.len);
            end
        end
    endtask

    // Monitor: measures every Aberto/Erro/Bloqueado pulse and checks it
    // against the expectation queue when the pulse ends.
    initial begin
        run_a = 0;
        run_e = 0;
        run_b = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("exclusive", $countones({Aberto, Erro, Bloqueado}) > 1 ? 1 : 0, 0);
            end
            if (Aberto === 1'b1) run_a++;
            else if (run_a != 0) begin report(0, run_a); run_a = 0; end
            if (Erro === 1'b1) run_e++;
            else if (run_e != 0) begin report(1, run_e); run_e = 0; end
            if (Bloqueado === 1'b1) run_b++;
            else if (run_b != 0) begin report(2, run_b); run_b = 0; end
        end
    end

    task automatic wait_hab(input string name);
        int n;
        n = 0;
        while (HabReg !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (HabReg !== 1'b1) chk(name, 0, 1);
    endtask

    task automatic send_digit(input logic [3:0] d);
        wait_hab("wait_coleta");
        Dado   = d;
        Pronto = 1'b1;
        @(negedge clk);
        Pronto = 1'b0;
    endtask

    task automatic send_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            send_digit(code[15-4*i -: 4]);
            chk("digitos_count", int'(Digitos), i + 1);
            chk("habreg_rearm", int'(HabReg), 0);
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, int'({HabReg, Aberto, Erro, Bloqueado, Digitos}), 0);
    endtask

    task automatic wait_out(input string name, input logic which_bloq);
        int n;
        n = 0;
        while (((which_bloq ? Bloqueado : Aberto) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(which_bloq ? Bloqueado : Aberto), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        Dado   = 4'h0;
        Pronto = 1'b1;
        Limpar = 1'b0;

        // 1 reset
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst    = 1'b1;
        Pronto = 1'b0;
        @(negedge clk);
        chk("habreg_after_release", int'(HabReg), 1);

        // 2 correct code
        expect_ev(0, 8);
        send_code(16'h1234);
        wait_hab("idle_after_open");
        chk("digitos_after_open", int'(Digitos), 0);

        // 3 wrong code, then a normal entry
        expect_ev(1, 1);
        send_code(16'h1235);
        wait_hab("idle_after_err");
        chk("digitos_after_err", int'(Digitos), 0);
        expect_ev(0, 8);
        send_code(16'h1234);

        // 4 lockout, digits ignored while locked
        expect_ev(1, 1);
        expect_ev(1, 1);
        expect_ev(2, 32);
        send_code(16'h9999);
        send_code(16'h0000);
        send_code(16'h4321);
        wait_out("bloqueado_start", 1'b1);
        Dado = 4'h7;
        repeat (5) begin
            Pronto = 1'b1;
            @(negedge clk);
            Pronto = 1'b0;
            @(negedge clk);
        end
        chk("digitos_in_lockout", int'(Digitos), 0);
        wait_hab("idle_after_lock");
        chk("digitos_after_lock", int'(Digitos), 0);
        expect_ev(0, 8);
        send_code(16'h1234);

        // 5 Limpar
        send_digit(4'h1);
        send_digit(4'h2);
        chk("digitos_before_limpar", int'(Digitos), 2);
        wait_hab("coleta_limpar");
        Limpar = 1'b1;
        @(negedge clk);
        Limpar = 1'b0;
        chk("digitos_after_limpar", int'(Digitos), 0);
        wait_hab("coleta_limpar_pronto");
        Limpar = 1'b1;
        Pronto = 1'b1;
        Dado   = 4'h9;
        @(negedge clk);
        Limpar = 1'b0;
        Pronto = 1'b0;
        chk("limpar_beats_pronto", int'(Digitos), 0);
        expect_ev(0, 8);
        send_code(16'h1234);

        // 6 reset during Aberto cycle 3
        expect_ev(0, 3);
        send_code(16'h1234);
        wait_out("aberto_start", 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_aberto");
        rst = 1'b1;

        // reset during Bloqueado cycle 10, then error count must restart at 0
        expect_ev(1, 1);
        expect_ev(1, 1);
        expect_ev(2, 10);
        send_code(16'h1111);
        send_code(16'h2222);
        send_code(16'h3333);
        wait_out("bloqueado_start2", 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_bloqueio");
        rst = 1'b1;
        expect_ev(1, 1);
        expect_ev(1, 1);
        expect_ev(2, 32);
        send_code(16'h5555);
        send_code(16'h6666);
        send_code(16'h7777);
        wait_hab("idle_final");

        repeat (5) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
